// File: rtl/operand_packer.sv
// operand_packer: packs a serial valid/ready word stream into four-word groups and
// issues each group as parallel operands a..d to the (a+b)*(c+d)+a*d datapath.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   s_data/s_valid   stream word and its valid
//   s_ready          high from the first edge after reset release; no back-pressure
//   s_last           marks the 4th word of a group
//   flush            synchronous abort of the partial group
//   a, b, c, d       packed operands, held until the next issue
//   op_valid         one-cycle strobe: a..d hold a fresh group
//   res_valid        op_valid delayed PIPE_LATENCY cycles (datapath y valid)
//   frame_err        one-cycle strobe on a malformed group
//   err_count        saturating count of frame_err pulses
//   in_flight        groups issued whose res_valid has not fired yet
module operand_packer #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned PIPE_LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] d,
    output logic                  op_valid,
    output logic                  res_valid,
    output logic                  frame_err,
    output logic [7:0]            err_count,
    output logic [3:0]            in_flight
);

    typedef enum logic [0:0] {StCollect, StDrop} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic                    s_ready_q, s_ready_d;
    logic                    op_valid_q, op_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic [7:0]              err_count_q, err_count_d;
    logic [PIPE_LATENCY-1:0] dly_q, dly_d;
    logic [3:0]              in_flight_q, in_flight_d;
    logic                    xfer;

    assign xfer = s_valid && s_ready_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sh_c_d      = sh_c_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        s_ready_d   = 1'b1;
        op_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (flush) begin
            // Any word arriving alongside flush is dropped silently.
            idx_d   = 2'd0;
            state_d = StCollect;
        end else if (xfer) begin
            case (state_q)
                StCollect: begin
                    if (idx_q != 2'd3) begin
                        if (s_last) begin
                            frame_err_d = 1'b1;
                            idx_d       = 2'd0;
                        end else begin
                            case (idx_q)
                                2'd0:    sh_a_d = s_data;
                                2'd1:    sh_b_d = s_data;
                                default: sh_c_d = s_data;
                            endcase
                            idx_d = idx_q + 2'd1;
                        end
                    end else if (s_last) begin
                        // Fourth word goes straight to d; no shadow slot needed.
                        a_d        = sh_a_q;
                        b_d        = sh_b_q;
                        c_d        = sh_c_q;
                        d_d        = s_data;
                        op_valid_d = 1'b1;
                        idx_d      = 2'd0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StDrop;
                    end
                end
                StDrop: begin
                    if (s_last) begin
                        state_d = StCollect;
                        idx_d   = 2'd0;
                    end
                end
                default: state_d = StCollect;
            endcase
        end

        err_count_d = err_count_q;
        if (frame_err_d && (err_count_q != 8'hff)) begin
            err_count_d = err_count_q + 8'd1;
        end

        dly_d[0] = op_valid_q;
        for (int i = 1; i < int'(PIPE_LATENCY); i++) begin
            dly_d[i] = dly_q[i-1];
        end

        // Tracks the next-cycle outputs so in_flight agrees with op_valid/res_valid.
        in_flight_d = in_flight_q;
        case ({op_valid_d, dly_d[PIPE_LATENCY-1]})
            2'b10:   in_flight_d = in_flight_q + 4'd1;
            2'b01:   in_flight_d = in_flight_q - 4'd1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StCollect;
            idx_q       <= 2'd0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sh_c_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            s_ready_q   <= 1'b0;
            op_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'd0;
            dly_q       <= '0;
            in_flight_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sh_c_q      <= sh_c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            s_ready_q   <= s_ready_d;
            op_valid_q  <= op_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            dly_q       <= dly_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign op_valid  = op_valid_q;
    assign res_valid = dly_q[PIPE_LATENCY-1];
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
    assign in_flight = in_flight_q;

endmodule

// File: tb/tb_operand_packer.sv
module tb_operand_packer;
    localparam int DW  = 16;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          flush = 1'b0;
    logic          s_ready;
    logic [DW-1:0] a, b, c, d;
    logic          op_valid, res_valid, frame_err;
    logic [7:0]    err_count;
    logic [3:0]    in_flight;

    operand_packer #(.DATA_WIDTH(DW), .PIPE_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .flush(flush), .a(a), .b(b), .c(c), .d(d),
        .op_valid(op_valid), .res_valid(res_valid), .frame_err(frame_err),
        .err_count(err_count), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int op_seen = 0, res_seen = 0, fe_seen = 0, peak = 0;
    logic [4*DW-1:0] exp_q[$];  // expected operand groups, in issue order
    int              iss_q[$];  // issue cycles awaiting res_valid
    logic [4*DW-1:0] e;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor / scoreboard consumer, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (op_valid) begin
                op_seen++;
                if (exp_q.size() == 0) chk("op_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("operands", {a, b, c, d}, e);
                end
                iss_q.push_back(cyc);
            end
            if (res_valid) begin
                res_seen++;
                if (iss_q.size() == 0) chk("res_unexpected", 1, 0);
                else chk("res_latency", cyc - iss_q.pop_front(), LAT);
            end
            if (frame_err) fe_seen++;
            chk("in_flight", in_flight, iss_q.size());
            if (int'(in_flight) > peak) peak = in_flight;
        end
    end

    task automatic send(input logic [DW-1:0] w, input logic last, input logic fl = 1'b0);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = w;
        s_last  = last;
        flush   = fl;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        flush   = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic group(input logic [DW-1:0] wa, wb, wc, wd);
        exp_q.push_back({wa, wb, wc, wd});
        send(wa, 1'b0);
        send(wb, 1'b0);
        send(wc, 1'b0);
        send(wd, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() + iss_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", exp_q.size() + iss_q.size(), 0);
    endtask

    initial begin
        int fe0, op0, res0, n;
        #12;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_outputs", {a, b, c, d, op_valid, res_valid, frame_err, err_count, in_flight}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_up", s_ready, 1);

        // Basic group: y = (1+2)*(3+4)+1*4 = 25 when res_valid fires.
        group(1, 2, 3, 4);
        idle(1);
        drain(30);

        // Early s_last.
        fe0 = fe_seen;
        send(5, 1'b0);
        send(6, 1'b1);
        group(1, 1, 1, 1);
        idle(1);
        drain(30);
        chk("fe_early_last", fe_seen - fe0, 1);
        chk("err_count_1", err_count, 1);

        // Missing s_last on 4th word, drop until last.
        fe0 = fe_seen;
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        send(9, 1'b0); send(9, 1'b1);
        group(2, 3, 4, 5);
        idle(1);
        drain(30);
        chk("fe_missing_last", fe_seen - fe0, 1);
        chk("err_count_2", err_count, 2);

        // Back-to-back full-rate groups.
        peak = 0;
        group(1, 2, 3, 4);
        group(5, 6, 7, 8);
        group(9, 10, 11, 12);
        idle(1);
        drain(40);
        chk("peak_in_flight", peak, 2);

        // Flush in COLLECT.
        fe0 = fe_seen;
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0, 1'b1);
        group(7, 8, 9, 10);
        idle(1);
        drain(30);
        chk("fe_flush", fe_seen - fe0, 0);
        // Flush in DROP returns to COLLECT.
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        send(5, 1'b0, 1'b1);
        group(11, 12, 13, 14);
        idle(1);
        drain(30);
        chk("fe_drop_flush", fe_seen - fe0, 1);
        chk("err_count_3", err_count, 3);

        // Reset two cycles after an op_valid: result is forgotten.
        op0 = op_seen;
        group(1, 2, 3, 4);
        idle(1);
        n = 0;
        while (op_seen == op0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_before_rst", op_seen - op0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {s_ready, a, b, c, d, op_valid, res_valid, frame_err, err_count, in_flight}, 0);
        exp_q.delete();
        iss_q.delete();
        res0 = res_seen;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("no_res_after_rst", res_seen - res0, 0);
        chk("in_flight_after_rst", in_flight, 0);

        // Saturation: 300 single-word malformed groups.
        fe0 = fe_seen;
        repeat (300) send(0, 1'b1);
        idle(3);
        @(negedge clk);
        chk("fe_sat_pulses", fe_seen - fe0, 300);
        chk("err_count_sat", err_count, 255);
        chk("no_stray_ops", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/operand_packer.md
# operand_packer

Upstream feeder for the four-operand multiply-add datapath, which computes y = (a+b)*(c+d) + a*d. It accepts a serial valid/ready stream of DATA_WIDTH-bit words and packs each four-word group into parallel operands a, b, c, d. It issues each group to the datapath as a one-cycle strobe. A latency-matched valid delay line flags the cycle in which the datapath's y output holds the result for that group.

## Interface
- DATA_WIDTH, 16, operand and stream word width
- PIPE_LATENCY, 5, number of cycles from the datapath sampling a..d to y being valid; range 1..15
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- s_data  in  DATA_WIDTH  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  packer can accept a word
- s_last  in  1  marks the 4th word of a group
- flush  in  1  synchronous abort of the partial group
- a, b, c, d  out  DATA_WIDTH each  packed operands, held until the next issue
- op_valid  out  1  one-cycle strobe: a..d hold a fresh group
- res_valid  out  1  op_valid delayed PIPE_LATENCY cycles
- frame_err  out  1  one-cycle strobe on a malformed group
- err_count  out  8  frame_err count, saturating at 255
- in_flight  out  4  groups issued whose res_valid has not yet fired

## Operation
- Handshake: a word transfers on a rising edge where s_valid && s_ready. s_ready = 0 during reset, then 1 from the first edge after release. There is no back-pressure otherwise; the datapath never stalls.
- Word index idx (0..3) selects the shadow slot: word0→a, word1→b, word2→c, word3→d.
- FSM state COLLECT:
  - Handshake with idx<3 and !s_last: store the word, idx++.
  - Handshake with idx<3 and s_last: frame_err pulse, err_count+1, idx←0. The group is discarded.
  - Handshake with idx==3 and s_last: load a..d from the shadow slots plus s_data, op_valid←1, idx←0.
  - Handshake with idx==3 and !s_last: frame_err pulse, err_count+1, go to DROP.
- FSM state DROP: words are accepted and discarded. A handshake with s_last → COLLECT, idx←0. No further frame_err.
- flush=1 overrides everything:
  - idx←0 and state←COLLECT.
  - Any word transferred in that cycle is discarded, with no op_valid and no frame_err.
  - a..d, the delay line and err_count are unaffected.
- Delay line: a PIPE_LATENCY-stage shift register of op_valid; its last stage drives res_valid.
- in_flight: +1 on op_valid, −1 on res_valid, unchanged when both occur together.
- err_count saturates at 255; frame_err still pulses.
- Reset values: s_ready 0, a..d 0, op_valid 0, res_valid 0, frame_err 0, err_count 0, in_flight 0, idx 0, state COLLECT, delay line all 0.

## Timing
- Issue timing: if the 4th word transfers on edge E, a..d update and op_valid=1 during the cycle after E. op_valid drops after one cycle; a..d hold.
- The datapath samples a..d on edge E+1. res_valid is high exactly PIPE_LATENCY cycles after op_valid, i.e. in the cycle after edge E+PIPE_LATENCY. This is the cycle in which y holds that group's result.
- Full-rate throughput: one group every 4 cycles. in_flight ≤ ceil(PIPE_LATENCY/4)+1.
- frame_err is high in the cycle after the offending handshake edge.
- Reset mid-operation clears all state asynchronously. In-flight results are forgotten: res_valid does not fire for them.

## Test plan
- Words 1,2,3,4 (last on 4) → a=1, b=2, c=3, d=4, op_valid for 1 cycle. res_valid 5 cycles later, when datapath y=25. in_flight goes 1→0.
- Words 5,6 with s_last on 6, then a valid group 1,1,1,1 → frame_err once, err_count=1, no op_valid for the bad group. The next group issues normally (y=5).
- Words 1,2,3,4,9,9 with last only on the 6th, then a valid group → frame_err at the 4th word. Words 4..6 are dropped. The next group issues correctly.
- Three back-to-back groups with s_valid held high → op_valid every 4 cycles, in_flight peaks at 2, three res_valid pulses each 5 cycles after their op_valid.
- Two words, then flush=1 together with a third word, then words 7,8,9,10 → no op_valid for the aborted data, a=7, b=8, c=9, d=10. Also: flush during DROP returns to COLLECT.
- rst pulsed low 2 cycles after an op_valid → all outputs 0 immediately, and no res_valid for that group. Separately, 300 malformed groups → err_count=255.
